pipe_hazard_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage CPU. It drives the PC enable, the IF/ID enable and flush, and the ID/EX bubble injection, so the hazard-free pipeline registers execute correctly. It handles three cases: load-use RAW hazards (multi-cycle bubbles), taken branches/jumps resolved in EX, and memory-indirect jumps whose target arrives in MEM. It also honours a data-memory wait freeze and keeps a saturating bubble counter for performance measurement.

---
 rtl/pipe_pkg.sv | 5 +
 rtl/raw_cmp.sv | 13 +
 rtl/pipe_hazard_ctrl.sv | 96 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-control state encoding and register-index width.
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, JMEM = 2'd2} state_t;
  localparam int REG_W = 6;
endpackage

// File: rtl/raw_cmp.sv
// raw_cmp: source/destination register index match gated by the use-enables.
module raw_cmp #(
  parameter int REG_W = 6
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic             hit
);
  assign hit = (uses_rs && rs == rd) || (uses_rt && rt == rd);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stalls, EX branch squash, memory-indirect jumps and freeze.
module pipe_hazard_ctrl #(
  parameter int REG_W        = pipe_pkg::REG_W,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_r,
  input  logic             ex_taken,
  input  logic             ex_jump_mem,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             pc_src_mem,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bubble_cnt
);
  import pipe_pkg::*;
  logic [1:0] st, nx, cnt, cnt_nx;
  logic hit, lu, ifid_ld;
  raw_cmp #(.REG_W(REG_W)) u_cmp (
    .rs(id_rs), .rt(id_rt), .rd(ex_rd),
    .uses_rs(id_uses_rs), .uses_rt(id_uses_rt), .hit(hit)
  );
  assign lu = ex_mem_r && ex_reg_write && hit;
  assign state = st;
  assign ifid_en = ifid_ld || ifid_flush;
  always_comb begin
    pc_en = 1'b0;
    pc_src_mem = 1'b0;
    ifid_ld = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    nx = st;
    cnt_nx = cnt;
    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      nx = RUN;
      cnt_nx = 2'd0;
    end else if (!mem_wait) begin
      if (st == STALL) begin
        idex_flush = 1'b1;
        cnt_nx = cnt - 2'd1;
        nx = (cnt <= 2'd1) ? RUN : STALL;
      end else if (st == JMEM) begin
        pc_en = 1'b1;
        pc_src_mem = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        nx = RUN;
      end else begin
        // RUN, and the illegal encoding which behaves as RUN
        nx = RUN;
        if (ex_jump_mem) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          nx = JMEM;
        end else if (ex_taken) begin
          pc_en = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu) begin
          idex_flush = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            cnt_nx = 2'(LOAD_BUBBLES - 1);
            nx = STALL;
          end
        end else begin
          pc_en = 1'b1;
          ifid_ld = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= RUN;
      cnt <= 2'd0;
      bubble_cnt <= '0;
    end else begin
      st <= nx;
      cnt <= cnt_nx;
      if (idex_flush && !mem_wait && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle stall/jump/reset sequences.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_r, ex_taken, ex_jump_mem, mem_wait;
  logic pc_en, pc_src_mem, ifid_en, ifid_flush, idex_flush;
  logic [1:0] state, bubble_cnt;
  int nvec = 0;
  int nmis = 0;
  typedef struct {
    logic [5:0] rs, rt, rd;
    logic urs, urt, rw, mr, tk, jm, mw;
    logic pc, src, ie, ifl, xfl;
    logic [1:0] ns, bc;
  } vec_t;
  vec_t v[14];
  pipe_hazard_ctrl #(.REG_W(6), .LOAD_BUBBLES(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_r(ex_mem_r), .ex_taken(ex_taken),
    .ex_jump_mem(ex_jump_mem), .mem_wait(mem_wait), .pc_en(pc_en),
    .pc_src_mem(pc_src_mem), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .state(state), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic outs(input string n, input logic pc, src, ie, ifl, xfl);
    chk({n, ".pc_en"}, pc_en, pc);
    chk({n, ".pc_src_mem"}, pc_src_mem, src);
    chk({n, ".ifid_en"}, ifid_en, ie);
    chk({n, ".ifid_flush"}, ifid_flush, ifl);
    chk({n, ".idex_flush"}, idex_flush, xfl);
  endtask
  task automatic drive(input vec_t x);
    id_rs = x.rs; id_rt = x.rt; ex_rd = x.rd;
    id_uses_rs = x.urs; id_uses_rt = x.urt; ex_reg_write = x.rw; ex_mem_r = x.mr;
    ex_taken = x.tk; ex_jump_mem = x.jm; mem_wait = x.mw;
  endtask
  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_reg_write = 0; ex_mem_r = 0; ex_taken = 0; ex_jump_mem = 0; mem_wait = 0;
  endtask
  task automatic lu_in();
    idle();
    ex_mem_r = 1; ex_reg_write = 1; ex_rd = 5; id_uses_rt = 1; id_rt = 5;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          rs rt rd urs urt rw mr tk jm mw  pc src ie ifl xfl ns bc
    v[0]  = '{0, 6, 5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    v[1]  = '{0, 5, 5, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    v[2]  = '{0, 5, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    v[3]  = '{5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    v[4]  = '{0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    v[5]  = '{0, 5, 5, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    v[6]  = '{0, 5, 5, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    v[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 2, 1};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 2, 1};
    v[9]  = '{0, 5, 5, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    v[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    v[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    v[12] = '{7, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    v[13] = '{5, 3, 5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    idle();
    #2;
    outs("reset", 0, 0, 1, 1, 1);
    chk("reset.state", state, 0);
    chk("reset.bubble_cnt", bubble_cnt, 0);
    for (int i = 0; i < 14; i++) begin
      do_reset();
      drive(v[i]);
      #1;
      outs($sformatf("vec%0d", i), v[i].pc, v[i].src, v[i].ie, v[i].ifl, v[i].xfl);
      step();
      chk($sformatf("vec%0d.state", i), state, v[i].ns);
      chk($sformatf("vec%0d.bubble_cnt", i), bubble_cnt, v[i].bc);
    end
    // two-bubble load-use: RUN -> STALL -> RUN, then the ID instruction issues
    do_reset();
    lu_in();
    #1 outs("lu.c0", 0, 0, 0, 0, 1);
    step();
    chk("lu.c1.state", state, 1);
    outs("lu.c1", 0, 0, 0, 0, 1);
    step();
    chk("lu.c2.state", state, 0);
    chk("lu.c2.bubble_cnt", bubble_cnt, 2);
    idle();
    #1 outs("lu.c2", 1, 0, 1, 0, 0);
    // freeze for three cycles mid-stall, then saturate the 2-bit counter
    do_reset();
    lu_in();
    step();
    chk("frz.state", state, 1);
    mem_wait = 1;
    for (int k = 0; k < 3; k++) begin
      #1 outs($sformatf("frz%0d", k), 0, 0, 0, 0, 0);
      step();
      chk($sformatf("frz%0d.state", k), state, 1);
      chk($sformatf("frz%0d.bubble_cnt", k), bubble_cnt, 1);
    end
    mem_wait = 0;
    #1 outs("frz.resume", 0, 0, 0, 0, 1);
    step();
    chk("frz.end.state", state, 0);
    chk("frz.end.bubble_cnt", bubble_cnt, 2);
    idle();
    ex_taken = 1;
    step();
    chk("sat.3", bubble_cnt, 3);
    step();
    chk("sat.hold", bubble_cnt, 3);
    chk("sat.state", state, 0);
    // memory-indirect jump: detect, load PC from memory, back to RUN
    do_reset();
    idle();
    ex_jump_mem = 1;
    #1 outs("jm.c0", 0, 0, 1, 1, 1);
    step();
    chk("jm.c1.state", state, 2);
    ex_jump_mem = 0;
    ex_taken = 1;
    #1 outs("jm.c1", 1, 1, 1, 1, 1);
    step();
    ex_taken = 0;
    #1;
    chk("jm.c2.state", state, 0);
    chk("jm.c2.bubble_cnt", bubble_cnt, 2);
    outs("jm.c2", 1, 0, 1, 0, 0);
    // asynchronous reset in the middle of JMEM discards the pending jump
    do_reset();
    idle();
    ex_jump_mem = 1;
    step();
    chk("rj.state", state, 2);
    ex_jump_mem = 0;
    #2 rst_n = 1'b0;
    #1;
    outs("rj.inrst", 0, 0, 1, 1, 1);
    chk("rj.inrst.state", state, 0);
    chk("rj.inrst.bubble_cnt", bubble_cnt, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1 outs("rj.after", 1, 0, 1, 0, 0);
    step();
    chk("rj.after.state", state, 0);
    chk("rj.after.bubble_cnt", bubble_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
